qspi_target: RTL and testbench
==============================

Name: qspi_target

Overview:
- Quad-SPI responder that terminates the 4-lane SPI link driven by the off-chip controller.
- Decodes command and address, performs byte, halfword or word register accesses on an internal single-cycle register bus, and returns read data on CIPO.
- Sits between the chip pads (CS_N, SCK, COPI, CIPO) and the regfile inside digital_top.
- SCK and CS_N are oversampled in the clk domain; no logic is clocked by SCK.

Parameters:
- ADDR_W, 8, byte-address width.
- DUMMY_NIB, 2, turnaround nibbles between the end of the address and the first read-data nibble; minimum 1.
- SYNC_STAGES, 2, synchronizer depth on SCK, CS_N and COPI.

Ports:
- clk  in  1  system clock; must be at least 4x SCK frequency.
- rst_n  in  1  reset, synchronous, active-low.
- CS_N  in  1  chip select, active-low.
- SCK  in  1  SPI clock, mode 0 (idle low).
- COPI  in  4  controller-to-target nibble.
- CIPO  out  4  target-to-controller nibble.
- cipo_oe  out  1  CIPO pad enable.
- bus_addr  out  ADDR_W  word-aligned byte address; bits [1:0] are always 0.
- bus_we  out  1  write strobe, one-cycle pulse.
- bus_be  out  4  byte enables, valid with bus_we.
- bus_wdata  out  32  lane-aligned write data.
- bus_re  out  1  read strobe, one-cycle pulse.
- bus_rdata  in  32  read data, valid on the cycle after bus_re.
- busy  out  1  high while a transaction is in progress.

Behaviour:
- Reset (synchronous, rst_n low at a clk edge):
  - All outputs go to 0 and state goes to IDLE.
  - Reset asserted mid-transaction aborts it with no further bus strobes.
- Input sampling:
  - SCK, CS_N and COPI pass through SYNC_STAGES flops.
  - Rise = synced SCK 0->1; fall = synced SCK 1->0.
  - COPI is captured on rise.
  - CIPO updates on the clk cycle after fall.
- Frame format, nibbles MSB-first:
  - CMD: 2 nibbles. cmd[7] = 1 read / 0 write; cmd[1:0] = size (0 byte, 1 halfword, 2 word, 3 reserved).
  - ADDR: ADDR_W/4 nibbles.
  - Write: data of 2, 4 or 8 nibbles.
  - Read: DUMMY_NIB nibbles, then 2, 4 or 8 nibbles on CIPO.
- States: IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, DONE, ERR.
  - IDLE -> CMD when synced CS_N falls.
  - CMD -> ADDR after 2 nibbles.
  - ADDR -> WDATA (write), DUMMY (read), or ERR.
  - WDATA -> DONE after the last nibble.
  - DUMMY -> RDATA after DUMMY_NIB nibbles.
  - RDATA -> DONE after the last nibble.
  - Any state -> IDLE on synced CS_N high.
- Error handling:
  - Reserved size, or misaligned address (halfword with addr[0]=1, word with addr[1:0]!=0), goes to ERR.
  - ERR issues no bus access and drives CIPO = 0 until CS_N rises.
- Write:
  - On the clk cycle after the last data nibble is captured, bus_we pulses for one cycle.
  - bus_wdata = data << (8*addr[1:0]); bus_be = {1, 3, F}[size] << addr[1:0].
  - Exactly one pulse per frame.
  - CS_N rising before the last nibble: no write.
- Read:
  - bus_re pulses for one cycle on the clk cycle after the last address nibble.
  - bus_rdata is latched one cycle later.
  - The latched word is shifted right by 8*addr[1:0]; the low 8, 16 or 32 bits are sent MSB-first.
  - The first data nibble appears after the fall that ends the last dummy nibble.
- CIPO and cipo_oe:
  - CIPO = 0 outside RDATA.
  - cipo_oe = 1 only in DUMMY and RDATA.
- DONE: extra SCK edges are ignored and CIPO = 0. A new frame requires CS_N high then low.
- busy = (state != IDLE).
- Simultaneous CS_N rise and SCK edge: CS_N wins, and the edge is ignored.
- bus_addr holds its last value between transactions.

Test Plan:
- Write word 0xAAAAAA to addr 112 (cmd 0x02, addr 0x70, nibbles 00AAAAAA) -> single bus_we; bus_addr = 0x70, bus_be = 4'hF, bus_wdata = 0x00AAAAAA.
- Write halfword 789 (0x0315) to addr 14 -> bus_addr = 0x0C, bus_be = 4'b1100, bus_wdata = 0x03150000, one pulse.
- Read byte at addr 0, with bus_rdata = 0x00000055 after bus_re -> CIPO nibbles 5 then 5 after 2 dummy nibbles; cipo_oe high through DUMMY and RDATA.
- Read halfword at addr 22, with bus_rdata = 0x05AB0000 -> CIPO nibbles 0, 5, A, B.
- Abort and error cases:
  - Write word with CS_N raised after 5 data nibbles -> no bus_we; busy drops within SYNC_STAGES+1 cycles.
  - Halfword write to addr 13 -> no bus_we; CIPO stays 0.
- Reset behaviour: rst_n low during RDATA -> next cycle all outputs 0 and state IDLE. Same-cycle reset-release re-entry (rst_n released with CS_N already low) -> no transaction until CS_N goes high then low.

Source files
------------

// File: rtl/qspi_target.sv
// Quad-SPI target: oversamples SCK/CS_N/COPI in the clk domain, decodes a
// command/address frame and performs one register-bus access per frame.
module qspi_target #(
   parameter int ADDR_W      = 8,
   parameter int DUMMY_NIB   = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              CS_N,
   input  logic              SCK,
   input  logic [3:0]        COPI,
   output logic [3:0]        CIPO,
   output logic              cipo_oe,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_we,
   output logic [3:0]        bus_be,
   output logic [31:0]       bus_wdata,
   output logic              bus_re,
   input  logic [31:0]       bus_rdata,
   output logic              busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE, S_ERR
   } state_t;

   localparam logic [7:0] ADDR_LAST = 8'(ADDR_W / 4 - 1);
   localparam logic [7:0] DUMMY_CNT = 8'(DUMMY_NIB);

   logic [SYNC_STAGES-1:0]      sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0]      cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0][3:0] copi_sync_q, copi_sync_d;
   logic                        sck_prev_q, sck_prev_d;
   logic                        cs_prev_q, cs_prev_d;

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              rd_q, rd_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       data_q, data_d;
   logic              rd_lat_q, rd_lat_d;

   logic [3:0]        cipo_q, cipo_d;
   logic              cipo_oe_q, cipo_oe_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic              bus_we_q, bus_we_d;
   logic [3:0]        bus_be_q, bus_be_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              bus_re_q, bus_re_d;
   logic              busy_q, busy_d;

   logic              sck_s, cs_s;
   logic [3:0]        copi_s;
   logic              rise, fall, cs_fall;
   logic [7:0]        n_nib;
   logic [ADDR_W-1:0] addr_next;
   logic [31:0]       data_shift_in;
   logic [31:0]       rd_shifted;
   logic [3:0]        be_base;
   logic              bad_access;

   assign sck_s   = sck_sync_q[SYNC_STAGES-1];
   assign cs_s    = cs_sync_q[SYNC_STAGES-1];
   assign copi_s  = copi_sync_q[SYNC_STAGES-1];
   assign rise    = sck_s & ~sck_prev_q;
   assign fall    = ~sck_s & sck_prev_q;
   assign cs_fall = ~cs_s & cs_prev_q;

   assign n_nib         = 8'd2 << size_q;
   assign addr_next     = {addr_q[ADDR_W-5:0], copi_s};
   assign data_shift_in = {data_q[27:0], copi_s};
   assign rd_shifted    = bus_rdata >> {addr_q[1:0], 3'b000};

   always_comb begin
      case (size_q)
         2'd0:    be_base = 4'h1;
         2'd1:    be_base = 4'h3;
         default: be_base = 4'hF;
      endcase
   end

   assign bad_access = (size_q == 2'd3) ||
                       (size_q == 2'd1 && addr_next[0]) ||
                       (size_q == 2'd2 && addr_next[1:0] != 2'b00);

   always_comb begin
      sck_sync_d[0]  = SCK;
      cs_sync_d[0]   = CS_N;
      copi_sync_d[0] = COPI;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sck_sync_d[i]  = sck_sync_q[i-1];
         cs_sync_d[i]   = cs_sync_q[i-1];
         copi_sync_d[i] = copi_sync_q[i-1];
      end
      sck_prev_d = sck_s;
      cs_prev_d  = cs_s;

      state_d     = state_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      size_d      = size_q;
      addr_d      = addr_q;
      data_d      = data_q;
      rd_lat_d    = bus_re_q;
      cipo_d      = cipo_q;
      bus_addr_d  = bus_addr_q;
      bus_we_d    = 1'b0;
      bus_be_d    = bus_be_q;
      bus_wdata_d = bus_wdata_q;
      bus_re_d    = 1'b0;

      // Read word is left-aligned so the first nibble to send sits in [31:28].
      if (rd_lat_q) begin
         case (size_q)
            2'd0:    data_d = {rd_shifted[7:0], 24'h0};
            2'd1:    data_d = {rd_shifted[15:0], 16'h0};
            default: data_d = rd_shifted;
         endcase
      end

      if (cs_s) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cs_fall) begin
                  state_d = S_CMD;
                  cnt_d   = 8'd0;
                  data_d  = 32'h0;
               end
            end
            S_CMD: begin
               if (rise) begin
                  if (cnt_q == 8'd0) begin
                     rd_d  = copi_s[3];
                     cnt_d = 8'd1;
                  end else begin
                     size_d  = copi_s[1:0];
                     cnt_d   = 8'd0;
                     state_d = S_ADDR;
                  end
               end
            end
            S_ADDR: begin
               if (rise) begin
                  addr_d = addr_next;
                  cnt_d  = cnt_q + 8'd1;
                  if (cnt_q == ADDR_LAST) begin
                     cnt_d = 8'd0;
                     if (bad_access) begin
                        state_d = S_ERR;
                     end else if (rd_q) begin
                        state_d    = S_DUMMY;
                        bus_re_d   = 1'b1;
                        bus_addr_d = {addr_next[ADDR_W-1:2], 2'b00};
                     end else begin
                        state_d = S_WDATA;
                     end
                  end
               end
            end
            S_WDATA: begin
               if (rise) begin
                  data_d = data_shift_in;
                  cnt_d  = cnt_q + 8'd1;
                  if (cnt_q == n_nib - 8'd1) begin
                     state_d     = S_DONE;
                     bus_we_d    = 1'b1;
                     bus_addr_d  = {addr_q[ADDR_W-1:2], 2'b00};
                     bus_be_d    = be_base << addr_q[1:0];
                     bus_wdata_d = data_shift_in << {addr_q[1:0], 3'b000};
                  end
               end
            end
            S_DUMMY: begin
               if (rise && cnt_q != DUMMY_CNT) begin
                  cnt_d = cnt_q + 8'd1;
               end else if (fall && cnt_q == DUMMY_CNT) begin
                  state_d = S_RDATA;
                  cnt_d   = 8'd0;
                  cipo_d  = data_q[31:28];
                  data_d  = {data_q[27:0], 4'h0};
               end
            end
            S_RDATA: begin
               if (rise) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == n_nib - 8'd1) begin
                     state_d = S_DONE;
                  end
               end else if (fall) begin
                  cipo_d = data_q[31:28];
                  data_d = {data_q[27:0], 4'h0};
               end
            end
            default: begin
            end
         endcase
      end

      if (state_d != S_RDATA) begin
         cipo_d = 4'h0;
      end
      cipo_oe_d = (state_d == S_DUMMY) || (state_d == S_RDATA);
      busy_d    = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sck_sync_q  <= '0;
         // CS_N history clears to "selected" so a CS_N already low at reset
         // release is not mistaken for a fresh falling edge.
         cs_sync_q   <= '0;
         copi_sync_q <= '0;
         sck_prev_q  <= 1'b0;
         cs_prev_q   <= 1'b0;
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         rd_q        <= 1'b0;
         size_q      <= 2'd0;
         addr_q      <= '0;
         data_q      <= 32'h0;
         rd_lat_q    <= 1'b0;
         cipo_q      <= 4'h0;
         cipo_oe_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= 4'h0;
         bus_wdata_q <= 32'h0;
         bus_re_q    <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         sck_sync_q  <= sck_sync_d;
         cs_sync_q   <= cs_sync_d;
         copi_sync_q <= copi_sync_d;
         sck_prev_q  <= sck_prev_d;
         cs_prev_q   <= cs_prev_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         size_q      <= size_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         rd_lat_q    <= rd_lat_d;
         cipo_q      <= cipo_d;
         cipo_oe_q   <= cipo_oe_d;
         bus_addr_q  <= bus_addr_d;
         bus_we_q    <= bus_we_d;
         bus_be_q    <= bus_be_d;
         bus_wdata_q <= bus_wdata_d;
         bus_re_q    <= bus_re_d;
         busy_q      <= busy_d;
      end
   end

   assign CIPO      = cipo_q;
   assign cipo_oe   = cipo_oe_q;
   assign bus_addr  = bus_addr_q;
   assign bus_we    = bus_we_q;
   assign bus_be    = bus_be_q;
   assign bus_wdata = bus_wdata_q;
   assign bus_re    = bus_re_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_qspi_target.sv
// Directed bench for qspi_target: SPI frames driven nibble by nibble, SCK at clk/8.
module tb_qspi_target;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        CS_N = 1'b1;
   logic        SCK = 1'b0;
   logic [3:0]  COPI = 4'h0;
   logic [3:0]  CIPO;
   logic        cipo_oe;
   logic [7:0]  bus_addr;
   logic        bus_we;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_re;
   logic [31:0] bus_rdata = 32'h0;
   logic        busy;

   always #5 clk = ~clk;

   qspi_target #(.ADDR_W(8), .DUMMY_NIB(2), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n), .CS_N(CS_N), .SCK(SCK), .COPI(COPI),
      .CIPO(CIPO), .cipo_oe(cipo_oe), .bus_addr(bus_addr), .bus_we(bus_we),
      .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_re(bus_re),
      .bus_rdata(bus_rdata), .busy(busy)
   );

   int          vectors = 0;
   int          miscompares = 0;
   int          we_cnt = 0;
   int          re_cnt = 0;
   int          we_base, re_base;
   logic [7:0]  we_addr = 8'h0, re_addr = 8'h0;
   logic [3:0]  we_be = 4'h0;
   logic [31:0] we_data = 32'h0;
   logic [31:0] rd_val = 32'h0;
   logic [3:0]  rx;
   logic        oe_s;

   // Bus monitor.
   always @(posedge clk) begin
      if (bus_we) begin
         we_cnt  = we_cnt + 1;
         we_addr = bus_addr;
         we_be   = bus_be;
         we_data = bus_wdata;
      end
      if (bus_re) begin
         re_cnt  = re_cnt + 1;
         re_addr = bus_addr;
      end
   end

   // Register file: read data valid only on the cycle after bus_re.
   always @(posedge clk) begin
      bus_rdata <= bus_re ? rd_val : 32'hDEADBEEF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic nib(input logic [3:0] n);
      SCK  = 1'b0;
      COPI = n;
      repeat (4) @(negedge clk);
      rx   = CIPO;
      oe_s = cipo_oe;
      SCK  = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      nib(b[7:4]);
      nib(b[3:0]);
   endtask

   task automatic cs_low();
      CS_N = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic cs_high();
      SCK = 1'b0;
      repeat (4) @(negedge clk);
      CS_N = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_cipo", 32'(CIPO), 32'h0);
      check("rst_oe", 32'(cipo_oe), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_we", 32'(bus_we), 32'h0);
      check("rst_re", 32'(bus_re), 32'h0);
      check("rst_addr", 32'(bus_addr), 32'h0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Write word 0x00AAAAAA to 0x70, then extra SCK edges in DONE.
      we_base = we_cnt;
      cs_low();
      send_byte(8'h02);
      send_byte(8'h70);
      send_byte(8'h00); send_byte(8'hAA); send_byte(8'hAA); send_byte(8'hAA);
      send_byte(8'h55);
      check("ww_busy", 32'(busy), 32'h1);
      cs_high();
      check("ww_count", 32'(we_cnt - we_base), 32'd1);
      check("ww_addr", 32'(we_addr), 32'h70);
      check("ww_be", 32'(we_be), 32'hF);
      check("ww_data", we_data, 32'h00AAAAAA);
      check("ww_busy_end", 32'(busy), 32'h0);
      $display("write word addr=70 data=%h be=%h", we_data, we_be);

      // Write halfword 0x0315 to 14.
      we_base = we_cnt;
      cs_low();
      send_byte(8'h01);
      send_byte(8'h0E);
      send_byte(8'h03); send_byte(8'h15);
      cs_high();
      check("wh_count", 32'(we_cnt - we_base), 32'd1);
      check("wh_addr", 32'(we_addr), 32'h0C);
      check("wh_be", 32'(we_be), 32'hC);
      check("wh_data", we_data, 32'h03150000);
      $display("write half addr=0E data=%h be=%h", we_data, we_be);

      // Read byte at 0.
      rd_val  = 32'h00000055;
      re_base = re_cnt;
      cs_low();
      send_byte(8'h80);
      send_byte(8'h00);
      nib(4'h0); check("rb_dummy0_cipo", 32'(rx), 32'h0); check("rb_dummy0_oe", 32'(oe_s), 32'h1);
      nib(4'h0); check("rb_dummy1_cipo", 32'(rx), 32'h0); check("rb_dummy1_oe", 32'(oe_s), 32'h1);
      nib(4'h0); check("rb_nib0", 32'(rx), 32'h5); check("rb_nib0_oe", 32'(oe_s), 32'h1);
      nib(4'h0); check("rb_nib1", 32'(rx), 32'h5); check("rb_nib1_oe", 32'(oe_s), 32'h1);
      SCK = 1'b0;
      repeat (4) @(negedge clk);
      check("rb_done_cipo", 32'(CIPO), 32'h0);
      check("rb_done_oe", 32'(cipo_oe), 32'h0);
      check("rb_done_busy", 32'(busy), 32'h1);
      cs_high();
      check("rb_count", 32'(re_cnt - re_base), 32'd1);
      check("rb_addr", 32'(re_addr), 32'h00);
      $display("read byte addr=00 rdata=%h", rd_val);

      // Read halfword at 22.
      rd_val  = 32'h05AB0000;
      re_base = re_cnt;
      cs_low();
      send_byte(8'h81);
      send_byte(8'h16);
      nib(4'h0); nib(4'h0);
      nib(4'h0); check("rh_nib0", 32'(rx), 32'h0);
      nib(4'h0); check("rh_nib1", 32'(rx), 32'h5);
      nib(4'h0); check("rh_nib2", 32'(rx), 32'hA);
      nib(4'h0); check("rh_nib3", 32'(rx), 32'hB);
      cs_high();
      check("rh_count", 32'(re_cnt - re_base), 32'd1);
      check("rh_addr", 32'(re_addr), 32'h14);
      $display("read half addr=16 rdata=%h", rd_val);

      // Word write aborted after 5 data nibbles.
      we_base = we_cnt;
      cs_low();
      send_byte(8'h02);
      send_byte(8'h00);
      nib(4'h1); nib(4'h2); nib(4'h3); nib(4'h4); nib(4'h5);
      check("ab_busy_before", 32'(busy), 32'h1);
      CS_N = 1'b1;
      SCK  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("ab_busy_drop", 32'(busy), 32'h0);
      repeat (6) @(negedge clk);
      check("ab_no_write", 32'(we_cnt - we_base), 32'd0);
      $display("aborted write word addr=00");

      // Misaligned halfword write to 13.
      we_base = we_cnt;
      cs_low();
      send_byte(8'h01);
      send_byte(8'h0D);
      nib(4'h0); check("er_cipo0", 32'(rx), 32'h0);
      nib(4'h3); check("er_cipo1", 32'(rx), 32'h0); check("er_oe", 32'(oe_s), 32'h0);
      nib(4'h1); check("er_cipo2", 32'(rx), 32'h0);
      nib(4'h5); check("er_cipo3", 32'(rx), 32'h0);
      check("er_busy", 32'(busy), 32'h1);
      cs_high();
      check("er_no_write", 32'(we_cnt - we_base), 32'd0);
      $display("misaligned write half addr=0D");

      // Reset during RDATA of a word read at 4.
      rd_val = 32'h12345678;
      cs_low();
      send_byte(8'h82);
      send_byte(8'h04);
      nib(4'h0); nib(4'h0);
      nib(4'h0); check("rr_nib0", 32'(rx), 32'h1);
      nib(4'h0); check("rr_nib1", 32'(rx), 32'h2);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rr_cipo", 32'(CIPO), 32'h0);
      check("rr_oe", 32'(cipo_oe), 32'h0);
      check("rr_busy", 32'(busy), 32'h0);
      check("rr_addr", 32'(bus_addr), 32'h0);
      check("rr_be", 32'(bus_be), 32'h0);
      check("rr_wdata", bus_wdata, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      $display("reset during read word addr=04");

      // CS_N still low at reset release: the frame must be ignored.
      we_base = we_cnt;
      re_base = re_cnt;
      repeat (2) @(negedge clk);
      nib(4'h0); nib(4'h0);
      check("re_busy0", 32'(busy), 32'h0);
      nib(4'h0); nib(4'h3);
      nib(4'hA); nib(4'h5);
      check("re_busy1", 32'(busy), 32'h0);
      cs_high();
      check("re_no_write", 32'(we_cnt - we_base), 32'd0);
      check("re_no_read", 32'(re_cnt - re_base), 32'd0);
      $display("ignored frame after reset release");

      // Fresh frame after CS_N high then low: byte write 0xA5 to 3.
      we_base = we_cnt;
      cs_low();
      send_byte(8'h00);
      send_byte(8'h03);
      send_byte(8'hA5);
      cs_high();
      check("wb_count", 32'(we_cnt - we_base), 32'd1);
      check("wb_addr", 32'(we_addr), 32'h00);
      check("wb_be", 32'(we_be), 32'h8);
      check("wb_data", we_data, 32'hA5000000);
      $display("write byte addr=03 data=%h be=%h", we_data, we_be);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
